// File: rtl/csa_seq_pkg.sv
// Shared types and helpers for the sequential carry-select adder.
package csa_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice-index width, kept at least one bit so a single-slice build still has a counter.
  function automatic int idx_width(input int width, input int chunk);
    int n;
    n = width / chunk;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/csa_chunk.sv
// One carry-select slice: both carry-in results are formed up front, then cin picks one.
module csa_chunk #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a_s,
  input  logic [CHUNK-1:0] b_s,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] sum0;
  logic [CHUNK:0] sum1;

  assign sum0 = {1'b0, a_s} + {1'b0, b_s};
  assign sum1 = {1'b0, a_s} + {1'b0, b_s} + (CHUNK+1)'(1);

  assign s    = cin ? sum1[CHUNK-1:0] : sum0[CHUNK-1:0];
  assign cout = cin ? sum1[CHUNK]     : sum0[CHUNK];

endmodule

// File: rtl/csa_seq_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per cycle, LSB first, with
// valid/ready handshakes on both sides.
module csa_seq_adder
  import csa_seq_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int IDX_W  = idx_width(WIDTH, CHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("csa_seq_adder: WIDTH must be a multiple of CHUNK");
  end

  state_t           state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             c_out_reg;
  logic             ovf_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;

  logic [CHUNK-1:0] a_slice [NSLICE];
  logic [CHUNK-1:0] b_slice [NSLICE];
  logic [CHUNK-1:0] a_s;
  logic [CHUNK-1:0] b_s;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_cout;

  for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
    assign a_slice[gi] = a_reg[gi*CHUNK +: CHUNK];
    assign b_slice[gi] = b_reg[gi*CHUNK +: CHUNK];
  end

  always_comb begin
    a_s = '0;
    b_s = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        a_s = a_slice[i];
        b_s = b_slice[i];
      end
    end
  end

  csa_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_s  (a_s),
    .b_s  (b_s),
    .cin  (carry_reg),
    .s    (chunk_s),
    .cout (chunk_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      carry_reg     <= 1'b0;
      sum_reg       <= '0;
      c_out_reg     <= 1'b0;
      ovf_reg       <= 1'b0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          in_ready_reg <= 1'b1;
          if (in_valid && in_ready_reg) begin
            // Subtraction is a + ~b + 1, so the +1 rides in on the carry.
            a_reg        <= a;
            b_reg        <= sub ? ~b : b;
            carry_reg    <= sub | c_in;
            idx_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= BUSY;
          end
        end
        BUSY: begin
          for (int i = 0; i < NSLICE; i++) begin
            if (idx_reg == IDX_W'(i)) begin
              sum_reg[i*CHUNK +: CHUNK] <= chunk_s;
            end
          end
          carry_reg <= chunk_cout;
          idx_reg   <= idx_reg + IDX_W'(1);
          if (idx_reg == LAST_IDX) begin
            // The top slice is being written now, so its MSB is the final sum MSB.
            c_out_reg     <= chunk_cout;
            ovf_reg       <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                             (chunk_s[CHUNK-1] != a_reg[WIDTH-1]);
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg    <= IDLE;
          in_ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign sum       = sum_reg;
  assign c_out     = c_out_reg;
  assign ovf       = ovf_reg;

endmodule
